// File: rtl/pair_mismatch_logger_pkg.sv
// rtl/pair_mismatch_logger_pkg.sv - shared types and helpers for the pair mismatch logger
package pair_mismatch_logger_pkg;

    // One sample: two bits from the blocking stage, then two from the non-blocking stage
    localparam int PAIR_W   = 4;
    localparam int DEF_TS_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // FIFO entry layout: timestamp in the upper bits, sample in the low PAIR_W bits
    typedef struct packed {
        logic [DEF_TS_W-1:0] ts;
        logic [PAIR_W-1:0]   pair;
    } entry_t;

    function automatic logic [PAIR_W-1:0] pack_pair(
        input logic a_blk,
        input logic b_blk,
        input logic a_nb,
        input logic b_nb
    );
        return {a_blk, b_blk, a_nb, b_nb};
    endfunction

endpackage

// File: rtl/pair_mismatch_logger_fifo.sv
// rtl/pair_mismatch_logger_fifo.sv - first-word fall-through FIFO holding mismatch entries
module sync_fifo_fwft #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves at the same edge
    assign do_push = push && (!full || do_pop);

    // Head is presented straight from the array; forced to zero while empty
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; clear wins over any push or pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, reads are gated by empty
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pair_mismatch_logger.sv
// rtl/pair_mismatch_logger.sv - logs cycles where blocking and non-blocking pair outputs diverge
module pair_mismatch_logger
    import pair_mismatch_logger_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TS_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     clear,
    input  logic                     a_blk,
    input  logic                     b_blk,
    input  logic                     a_nb,
    input  logic                     b_nb,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TS_W-1:0]          out_ts,
    output logic [PAIR_W-1:0]        out_pair,
    output logic [TS_W-1:0]          mismatch_cnt,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int WIDTH = TS_W + PAIR_W;

    state_t              state;
    state_t              state_nxt;
    logic [TS_W-1:0]     timestamp;
    logic [PAIR_W-1:0]   sample;
    logic                mismatch;
    logic                pop;
    logic                full;
    logic                empty;
    logic                drop;

    assign sample   = pack_pair(a_blk, b_blk, a_nb, b_nb);
    assign mismatch = (state == RUN) && (sample[3:2] != sample[1:0]);
    assign pop      = out_valid && out_ready;
    // Full implies a valid head, so the only escape from a drop is a same-edge pop
    assign drop     = mismatch && full && !pop;
    assign out_valid = !empty;

    // Capture state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Run/pause follows enable one edge later; clear does not touch state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable)  state_nxt = RUN;
            RUN:     if (!enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Free-running timestamp while capturing, wrapping silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             timestamp <= '0;
        else if (clear)         timestamp <= '0;
        else if (state == RUN)  timestamp <= timestamp + TS_W'(1);
    end

    // Mismatch total, including dropped entries, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               mismatch_cnt <= '0;
        else if (clear)                           mismatch_cnt <= '0;
        else if (mismatch && (mismatch_cnt != '1)) mismatch_cnt <= mismatch_cnt + TS_W'(1);
    end

    // Sticky flag for an entry lost to a full FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     overflow <= 1'b0;
        else if (clear) overflow <= 1'b0;
        else if (drop)  overflow <= 1'b1;
    end

    // Entry carries the pre-increment timestamp of the edge that saw the mismatch
    sync_fifo_fwft #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .push      (mismatch),
        .push_data ({timestamp, sample}),
        .pop       (pop),
        .pop_data  ({out_ts, out_pair}),
        .count     (fifo_count),
        .full      (full),
        .empty     (empty)
    );

endmodule
